usb_rx_decoder: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 11 +
 rtl/usb_rx_bit_timer.sv | 55 +++++
 rtl/usb_rx_decoder.sv | 161 ++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
// No latency or flow control here: enums and localparams only.
package usb_rx_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, RECEIVE, EOP1, EOP2, ERROR} rx_state_t;
  typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam int         MAX_ONES  = 6;

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Synchronizes D+/D-, re-centres a bit timer on every D+ edge and strobes mid-bit.
// Latency SYNC_FLOPS clks to line state; strobe CLKS_PER_BIT/2 clks after an edge; no backpressure.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_FLOPS   = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  d_plus_in,
  input  logic  d_minus_in,
  input  logic  restart,
  output logic  strobe,
  output line_t line,
  output logic  line_se1
);
  localparam int TW = $clog2(CLKS_PER_BIT);

  logic [SYNC_FLOPS-1:0] dp_sync, dm_sync;
  logic                  dp, dm, dp_prev, dp_edge;
  logic [TW-1:0]         timer_q, timer;

  assign dp      = dp_sync[SYNC_FLOPS-1];
  assign dm      = dm_sync[SYNC_FLOPS-1];
  assign dp_edge = dp ^ dp_prev;
  // timer reads 0 during the edge cycle itself so the strobe lands mid-bit
  assign timer    = (dp_edge || restart) ? '0 : timer_q;
  assign strobe   = (timer == TW'(CLKS_PER_BIT / 2 - 1));
  assign line_se1 = dp & dm;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync <= '1;
      dm_sync <= '0;
      dp_prev <= 1'b1;
      timer_q <= '0;
    end else begin
      dp_sync <= {dp_sync[SYNC_FLOPS-2:0], d_plus_in};
      dm_sync <= {dm_sync[SYNC_FLOPS-2:0], d_minus_in};
      dp_prev <= dp;
      timer_q <= (timer == TW'(CLKS_PER_BIT - 1)) ? '0 : timer + TW'(1);
    end
  end

  always_comb begin
    line = LINE_SE0;
    unique case ({dp, dm})
      2'b10:   line = LINE_J;
      2'b01:   line = LINE_K;
      default: line = LINE_SE0;
    endcase
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB FS receive: NRZI decode, unstuffing, SYNC check, LSB-first bytes, EOP/error detection.
// Byte valid one clk after the strobe of its last bit; no backpressure, consumer must keep up.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_FLOPS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);
  rx_state_t  state, state_n;
  line_t      line, prev_line, prev_n;
  logic       strobe, line_se1, restart, bit_val, fail;
  logic [2:0] ones, ones_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, byte_n, data_n;
  logic       valid_n, eop_n, active_n, error_n;

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_FLOPS  (SYNC_FLOPS)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .d_plus_in (d_plus_in),
    .d_minus_in(d_minus_in),
    .restart   (restart),
    .strobe    (strobe),
    .line      (line),
    .line_se1  (line_se1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      prev_line     <= LINE_J;
      ones          <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_active     <= 1'b0;
      rx_eop        <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      state         <= state_n;
      prev_line     <= prev_n;
      ones          <= ones_n;
      bit_cnt       <= bit_cnt_n;
      shift         <= shift_n;
      rx_data       <= data_n;
      rx_data_valid <= valid_n;
      rx_active     <= active_n;
      rx_eop        <= eop_n;
      rx_error      <= error_n;
    end
  end

  always_comb begin
    state_n   = state;
    prev_n    = prev_line;
    ones_n    = ones;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_n    = rx_data;
    valid_n   = 1'b0;
    eop_n     = 1'b0;
    active_n  = rx_active;
    error_n   = rx_error;
    restart   = 1'b0;
    fail      = 1'b0;
    bit_val   = (line == prev_line);
    byte_n    = {bit_val, shift[7:1]};

    unique case (state)
      IDLE: begin
        prev_n    = LINE_J;
        ones_n    = '0;
        bit_cnt_n = '0;
        if (line == LINE_K) begin
          restart = 1'b1;
          error_n = 1'b0;
          state_n = SYNC;
        end
      end
      SYNC, RECEIVE: if (strobe) begin
        if (line == LINE_SE0) begin
          if (state == SYNC || line_se1) fail = 1'b1;
          else                           state_n = EOP1;
        end else begin
          prev_n = line;
          // after six ones the next bit is a stuffed zero and never reaches the byte
          if (ones == 3'(MAX_ONES)) begin
            fail   = bit_val;
            ones_n = '0;
          end else begin
            ones_n    = bit_val ? ones + 3'd1 : 3'd0;
            shift_n   = byte_n;
            bit_cnt_n = (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == RECEIVE) begin
                data_n  = byte_n;
                valid_n = 1'b1;
              end else if (byte_n == SYNC_BYTE) begin
                active_n = 1'b1;
                state_n  = RECEIVE;
              end else begin
                fail = 1'b1;
              end
            end
          end
        end
      end
      EOP1: if (strobe) begin
        if (line == LINE_SE0) state_n = EOP2;
        else                  fail    = 1'b1;
      end
      EOP2: if (strobe) begin
        if (line == LINE_J && bit_cnt == 4'd0) begin
          eop_n    = 1'b1;
          active_n = 1'b0;
          state_n  = IDLE;
        end else begin
          fail = 1'b1;
        end
      end
      ERROR: begin
        active_n = 1'b0;
        // bit_cnt doubles as the idle-J run counter; SE0 neither counts nor breaks the run
        if (strobe) begin
          if (line == LINE_J) begin
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              state_n   = IDLE;
            end
          end else if (line == LINE_K) begin
            bit_cnt_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (fail) begin
      state_n   = ERROR;
      error_n   = 1'b1;
      active_n  = 1'b0;
      bit_cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: NRZI/stuffing encoder drives the line, monitor logs pulses.
// Each scenario task checks its own expected values inline.
module tb_usb_rx_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_plus_in = 1'b1;
  logic       d_minus_in = 1'b0;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_active, rx_eop, rx_error;

  usb_rx_decoder #(.CLKS_PER_BIT(8), .SYNC_FLOPS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_plus_in    (d_plus_in),
    .d_minus_in   (d_minus_in),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_active    (rx_active),
    .rx_eop       (rx_eop),
    .rx_error     (rx_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  // monitor, sampled on the falling edge
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         eop_cnt = 0;
  int         last_valid_cyc = 0;
  int         last_eop_cyc = 0;
  bit         seen_active = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (rx_data_valid) begin
        got_q.push_back(rx_data);
        last_valid_cyc = cyc;
      end
      if (rx_eop) begin
        eop_cnt = eop_cnt + 1;
        last_eop_cyc = cyc;
      end
      if (rx_active) seen_active = 1'b1;
    end
  end

  function automatic logic [7:0] got(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    eop_cnt = 0;
    seen_active = 1'b0;
  endtask

  // line encoder: decoded bits -> stuffing -> NRZI -> symbols, optional edge jitter
  bit tx_q[$];
  int ones_run = 0;
  bit lvl = 1'b1;
  int sym = 0;
  bit jit_on = 1'b0;
  int jit_tab[16] = '{0, 1, 1, 2, 2, 1, 1, 0, 0, -1, -1, -2, -2, -1, -1, 0};

  task automatic drive_sym(input bit dp, input bit dm);
    int n;
    n = jit_on ? 8 + jit_tab[(sym + 1) % 16] - jit_tab[sym % 16] : 8;
    d_plus_in  = dp;
    d_minus_in = dm;
    sym = sym + 1;
    repeat (n) @(negedge clk);
  endtask

  task automatic add_bit(input bit b, input bit stuff);
    tx_q.push_back(b);
    ones_run = b ? ones_run + 1 : 0;
    if (stuff && ones_run == 6) begin
      tx_q.push_back(1'b0);
      ones_run = 0;
    end
  endtask

  task automatic add_sync();
    ones_run = 0;
    for (int i = 0; i < 7; i++) add_bit(1'b0, 1'b1);
    add_bit(1'b1, 1'b1);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) add_bit(b[i], 1'b1);
  endtask

  task automatic send_bits();
    foreach (tx_q[i]) begin
      if (!tx_q[i]) lvl = ~lvl;
      drive_sym(lvl, ~lvl);
    end
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    lvl = 1'b1;
    repeat (n) drive_sym(1'b1, 1'b0);
  endtask

  task automatic eop(input int n_se0);
    repeat (n_se0) drive_sym(1'b0, 1'b0);
    idle(16);
  endtask

  task automatic test_reset();
    checks++; if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rx_data_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", rx_data_valid); end
    checks++; if (rx_active !== 1'b0) begin errs++; $display("FAIL reset_active: got %b want 0", rx_active); end
    checks++; if (rx_eop !== 1'b0) begin errs++; $display("FAIL reset_eop: got %b want 0", rx_eop); end
    checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL reset_error: got %b want 0", rx_error); end
  endtask

  task automatic test_basic_packet();
    clear_mon();
    idle(16);
    add_sync();
    add_byte(8'hA5);
    send_bits();
    checks++; if (rx_active !== 1'b1) begin errs++; $display("FAIL basic_active_mid: got %b want 1", rx_active); end
    eop(2);
    checks++; if (got_q.size() != 1) begin errs++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
    checks++; if (got(0) !== 8'hA5) begin errs++; $display("FAIL basic_byte: got %h want a5", got(0)); end
    checks++; if (eop_cnt != 1) begin errs++; $display("FAIL basic_eop: got %0d want 1", eop_cnt); end
    checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL basic_error: got %b want 0", rx_error); end
    checks++; if (rx_active !== 1'b0) begin errs++; $display("FAIL basic_active_end: got %b want 0", rx_active); end
    checks++; if (rx_data !== 8'hA5) begin errs++; $display("FAIL basic_hold: got %h want a5", rx_data); end
    checks++; if (last_eop_cyc - last_valid_cyc < 16) begin errs++; $display("FAIL basic_valid_to_eop: got %0d clks want >=16", last_eop_cyc - last_valid_cyc); end
  endtask

  task automatic test_bit_stuffing();
    clear_mon();
    idle(16);
    add_sync();
    add_byte(8'hFF);
    add_byte(8'h01);
    send_bits();
    eop(2);
    checks++; if (got_q.size() != 2) begin errs++; $display("FAIL stuff_count: got %0d want 2", got_q.size()); end
    checks++; if (got(0) !== 8'hFF) begin errs++; $display("FAIL stuff_byte0: got %h want ff", got(0)); end
    checks++; if (got(1) !== 8'h01) begin errs++; $display("FAIL stuff_byte1: got %h want 01", got(1)); end
    checks++; if (eop_cnt != 1) begin errs++; $display("FAIL stuff_eop: got %0d want 1", eop_cnt); end
    checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL stuff_error: got %b want 0", rx_error); end
  endtask

  task automatic test_stuff_error();
    clear_mon();
    idle(16);
    add_sync();
    for (int i = 0; i < 7; i++) add_bit(1'b1, 1'b0);
    send_bits();
    idle(16);
    checks++; if (rx_error !== 1'b1) begin errs++; $display("FAIL stufferr_error: got %b want 1", rx_error); end
    checks++; if (rx_active !== 1'b0) begin errs++; $display("FAIL stufferr_active: got %b want 0", rx_active); end
    checks++; if (got_q.size() != 0) begin errs++; $display("FAIL stufferr_valid: got %0d want 0", got_q.size()); end
    checks++; if (seen_active !== 1'b1) begin errs++; $display("FAIL stufferr_seen_active: got %b want 1", seen_active); end
    clear_mon();
    add_sync();
    add_byte(8'h3C);
    send_bits();
    eop(2);
    checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL stufferr_recover_error: got %b want 0", rx_error); end
    checks++; if (got(0) !== 8'h3C) begin errs++; $display("FAIL stufferr_recover_byte: got %h want 3c", got(0)); end
  endtask

  task automatic test_bad_sync();
    clear_mon();
    idle(16);
    for (int i = 0; i < 8; i++) add_bit(1'b0, 1'b0);
    send_bits();
    idle(16);
    checks++; if (seen_active !== 1'b0) begin errs++; $display("FAIL badsync_active: got %b want 0", seen_active); end
    checks++; if (rx_error !== 1'b1) begin errs++; $display("FAIL badsync_error: got %b want 1", rx_error); end
    checks++; if (got_q.size() != 0) begin errs++; $display("FAIL badsync_valid: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_bad_eop();
    clear_mon();
    idle(16);
    add_sync();
    add_byte(8'h5A);
    add_bit(1'b0, 1'b1); add_bit(1'b1, 1'b1); add_bit(1'b0, 1'b1); add_bit(1'b1, 1'b1);
    send_bits();
    eop(2);
    checks++; if (got(0) !== 8'h5A) begin errs++; $display("FAIL partial_byte: got %h want 5a", got(0)); end
    checks++; if (eop_cnt != 0) begin errs++; $display("FAIL partial_eop: got %0d want 0", eop_cnt); end
    checks++; if (rx_error !== 1'b1) begin errs++; $display("FAIL partial_error: got %b want 1", rx_error); end
    clear_mon();
    add_sync();
    add_byte(8'h81);
    send_bits();
    checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL short_se0_pre_error: got %b want 0", rx_error); end
    drive_sym(1'b0, 1'b0);
    drive_sym(1'b0, 1'b1);
    drive_sym(1'b0, 1'b1);
    idle(16);
    checks++; if (got(0) !== 8'h81) begin errs++; $display("FAIL short_se0_byte: got %h want 81", got(0)); end
    checks++; if (eop_cnt != 0) begin errs++; $display("FAIL short_se0_eop: got %0d want 0", eop_cnt); end
    checks++; if (rx_error !== 1'b1) begin errs++; $display("FAIL short_se0_error: got %b want 1", rx_error); end
  endtask

  task automatic test_jitter_and_reset();
    clear_mon();
    jit_on = 1'b1;
    sym = 0;
    idle(16);
    add_sync();
    add_byte(8'h5A);
    add_byte(8'hC3);
    add_byte(8'h96);
    send_bits();
    eop(2);
    jit_on = 1'b0;
    checks++; if (got_q.size() != 3) begin errs++; $display("FAIL jitter_count: got %0d want 3", got_q.size()); end
    checks++; if (got(0) !== 8'h5A) begin errs++; $display("FAIL jitter_byte0: got %h want 5a", got(0)); end
    checks++; if (got(1) !== 8'hC3) begin errs++; $display("FAIL jitter_byte1: got %h want c3", got(1)); end
    checks++; if (got(2) !== 8'h96) begin errs++; $display("FAIL jitter_byte2: got %h want 96", got(2)); end
    checks++; if (eop_cnt != 1 || rx_error !== 1'b0) begin errs++; $display("FAIL jitter_eop_error: got eop=%0d err=%b want 1/0", eop_cnt, rx_error); end

    clear_mon();
    add_sync();
    add_byte(8'hAB);
    add_bit(1'b1, 1'b1);
    add_bit(1'b0, 1'b1);
    send_bits();
    d_plus_in = lvl; d_minus_in = ~lvl;
    repeat (3) @(negedge clk);
    checks++; if (got(0) !== 8'hAB || rx_active !== 1'b1) begin errs++; $display("FAIL prereset_state: got data=%h act=%b want ab/1", got(0), rx_active); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    d_plus_in = 1'b1; d_minus_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    clear_mon();
    idle(16);
    add_sync();
    add_byte(8'h42);
    send_bits();
    eop(2);
    checks++; if (got_q.size() != 1 || got(0) !== 8'h42) begin errs++; $display("FAIL postreset_byte: got n=%0d data=%h want 1/42", got_q.size(), got(0)); end
    checks++; if (eop_cnt != 1) begin errs++; $display("FAIL postreset_eop: got %0d want 1", eop_cnt); end
    checks++; if (rx_error !== 1'b0) begin errs++; $display("FAIL postreset_error: got %b want 0", rx_error); end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic_packet();
    test_bit_stuffing();
    test_stuff_error();
    test_bad_sync();
    test_bad_eop();
    test_jitter_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
